// File: rtl/wb_i2c_bus_master_if.sv
// rtl/wb_i2c_bus_master_if.sv - Wishbone 8-bit/3-bit-address bus between the sequencer master and the I2C core

interface wb_i2c_bus_master_if;
  logic [2:0] o_wbs_adr;
  logic [7:0] o_wbs_dat;
  logic [7:0] i_wbs_dat;
  logic       o_wbs_we;
  logic       o_wbs_stb;
  logic       i_wbs_ack;
  logic       o_wbs_cyc;

  modport master (
    output o_wbs_adr,
    output o_wbs_dat,
    input  i_wbs_dat,
    output o_wbs_we,
    output o_wbs_stb,
    input  i_wbs_ack,
    output o_wbs_cyc
  );

  modport slave (
    input  o_wbs_adr,
    input  o_wbs_dat,
    output i_wbs_dat,
    input  o_wbs_we,
    input  o_wbs_stb,
    output i_wbs_ack,
    input  o_wbs_cyc
  );
endinterface

// File: rtl/wb_i2c_bus_master.sv
// rtl/wb_i2c_bus_master.sv - single-transfer Wishbone master turning sequencer read/write pulses into bus cycles
// Every bus and status output is registered; requests are only accepted while IDLE.

module wb_i2c_bus_master #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  wb_i2c_bus_master_if.master        wbs,
  input  logic                       i_ren,
  input  logic                       i_wren,
  input  logic [7:0]                 i_data,
  input  logic [2:0]                 i_addr,
  output logic [7:0]                 o_data,
  output logic                       o_data_val,
  output logic                       o_done,
  output logic                       o_busy,
  output logic                       o_err
);

  localparam int              CW     = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0]   TO_VAL = CW'(ACK_TIMEOUT);
  localparam bit              TO_EN  = (ACK_TIMEOUT != 0);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_adr,      w_adr_nxt;
  logic [7:0]    r_dat,      w_dat_nxt;
  logic          r_we,       w_we_nxt;
  logic [CW-1:0] r_cnt,      w_cnt_nxt;
  logic [7:0]    r_data,     w_data_nxt;
  logic          r_data_val, w_data_val_nxt;
  logic          r_done,     w_done_nxt;
  logic          r_err,      w_err_nxt;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state    <= S_IDLE;
      r_adr      <= '0;
      r_dat      <= '0;
      r_we       <= 1'b0;
      r_cnt      <= '0;
      r_data     <= '0;
      r_data_val <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_adr      <= w_adr_nxt;
      r_dat      <= w_dat_nxt;
      r_we       <= w_we_nxt;
      r_cnt      <= w_cnt_nxt;
      r_data     <= w_data_nxt;
      r_data_val <= w_data_val_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_adr_nxt      = r_adr;
    w_dat_nxt      = r_dat;
    w_we_nxt       = r_we;
    w_cnt_nxt      = r_cnt;
    w_data_nxt     = r_data;
    w_data_val_nxt = 1'b0;
    w_done_nxt     = 1'b0;
    w_err_nxt      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_wren) begin
          w_adr_nxt   = i_addr;
          w_dat_nxt   = i_data;
          w_we_nxt    = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_XFER;
        end else if (i_ren) begin
          w_adr_nxt   = i_addr;
          w_we_nxt    = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_XFER;
        end
      end
      S_XFER: begin
        // Ack wins over a timeout landing on the same edge.
        if (wbs.i_wbs_ack) begin
          w_state_nxt = S_IDLE;
          w_we_nxt    = 1'b0;
          w_done_nxt  = 1'b1;
          if (!r_we) begin
            w_data_nxt     = wbs.i_wbs_dat;
            w_data_val_nxt = 1'b1;
          end
        end else if (TO_EN && (r_cnt == TO_VAL)) begin
          w_state_nxt = S_IDLE;
          w_we_nxt    = 1'b0;
          w_done_nxt  = 1'b1;
          w_err_nxt   = 1'b1;
        end else if (TO_EN) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign wbs.o_wbs_cyc = (r_state == S_XFER);
  assign wbs.o_wbs_stb = (r_state == S_XFER);
  assign wbs.o_wbs_adr = r_adr;
  assign wbs.o_wbs_dat = r_dat;
  assign wbs.o_wbs_we  = r_we;

  assign o_data     = r_data;
  assign o_data_val = r_data_val;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_busy     = (r_state == S_XFER);

endmodule

// File: tb/tb_wb_i2c_bus_master.sv
// tb/tb_wb_i2c_bus_master.sv - directed self-checking bench for wb_i2c_bus_master with a one-cycle-ack slave model

module tb_wb_i2c_bus_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ren = 1'b0;
  logic       wren = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [2:0] addr = 3'd0;
  logic [7:0] rdata;
  logic       data_val, done, busy, err;

  int n_checks = 0;
  int n_fail = 0;

  wb_i2c_bus_master_if wb ();

  wb_i2c_bus_master #(.ACK_TIMEOUT(4)) dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .wbs        (wb),
    .i_ren      (ren),
    .i_wren     (wren),
    .i_data     (wdata),
    .i_addr     (addr),
    .o_data     (rdata),
    .o_data_val (data_val),
    .o_done     (done),
    .o_busy     (busy),
    .o_err      (err)
  );

  always #5 clk = ~clk;

  // Slave: registered ack one cycle after stb, read data from a table indexed by read count.
  logic       slv_mute = 1'b0;
  logic [7:0] rd_tab [4];
  logic       s_ack = 1'b0;
  logic [7:0] s_dat = 8'h00;
  int         rd_cnt = 0;
  int         wr_cnt = 0;
  logic [2:0] wr_adr = 3'd0;
  logic [7:0] wr_dat = 8'h00;

  assign wb.i_wbs_ack = s_ack;
  assign wb.i_wbs_dat = s_dat;

  always @(posedge clk) begin
    if (wb.o_wbs_cyc && wb.o_wbs_stb && !s_ack && !slv_mute) begin
      s_ack <= 1'b1;
      if (!wb.o_wbs_we) begin
        s_dat  <= rd_tab[rd_cnt % 4];
        rd_cnt <= rd_cnt + 1;
      end
    end else begin
      s_ack <= 1'b0;
    end
    if (wb.o_wbs_stb && s_ack && wb.o_wbs_we) begin
      wr_cnt <= wr_cnt + 1;
      wr_adr <= wb.o_wbs_adr;
      wr_dat <= wb.o_wbs_dat;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_cyc"}, 32'(wb.o_wbs_cyc), 32'd0);
    check_eq({tag, "_stb"}, 32'(wb.o_wbs_stb), 32'd0);
    check_eq({tag, "_we"},  32'(wb.o_wbs_we),  32'd0);
    check_eq({tag, "_adr"}, 32'(wb.o_wbs_adr), 32'd0);
    check_eq({tag, "_dat"}, 32'(wb.o_wbs_dat), 32'd0);
    check_eq({tag, "_data"}, 32'(rdata), 32'd0);
    check_eq({tag, "_flags"}, {28'd0, data_val, done, busy, err}, 32'd0);
  endtask

  int wr_base, dones, vals, rises, err_cyc, err_n;
  logic prev_stb;
  logic [7:0] vseq [3];

  initial begin
    rd_tab[0] = 8'h02; rd_tab[1] = 8'h02; rd_tab[2] = 8'h02; rd_tab[3] = 8'h00;

    tick(); tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Write addr 2 data 0x80
    wr_base = wr_cnt;
    wren = 1'b1; addr = 3'd2; wdata = 8'h80;
    tick();
    wren = 1'b0;
    check_eq("wr_c1_ctl", {29'd0, wb.o_wbs_cyc, wb.o_wbs_stb, wb.o_wbs_we}, 32'h7);
    check_eq("wr_c1_adr", 32'(wb.o_wbs_adr), 32'd2);
    check_eq("wr_c1_dat", 32'(wb.o_wbs_dat), 32'h80);
    check_eq("wr_c1_busy_done", {30'd0, busy, done}, 32'h2);
    tick();
    check_eq("wr_c2_ctl", {29'd0, wb.o_wbs_cyc, wb.o_wbs_stb, wb.o_wbs_we}, 32'h7);
    check_eq("wr_c2_done", 32'(done), 32'd0);
    tick();
    check_eq("wr_c3_ctl", {29'd0, wb.o_wbs_cyc, wb.o_wbs_stb, wb.o_wbs_we}, 32'h0);
    check_eq("wr_c3_flags", {28'd0, data_val, done, busy, err}, 32'h4);
    tick();
    check_eq("wr_c4_done", 32'(done), 32'd0);
    check_eq("wr_slave_cnt", 32'(wr_cnt - wr_base), 32'd1);
    check_eq("wr_slave_ad", {21'd0, wr_adr, wr_dat}, {21'd0, 3'd2, 8'h80});

    // Single read addr 4 returning 0x02
    ren = 1'b1; addr = 3'd4;
    tick();
    ren = 1'b0;
    check_eq("rd_c1_ctl", {29'd0, wb.o_wbs_cyc, wb.o_wbs_stb, wb.o_wbs_we}, 32'h6);
    check_eq("rd_c1_adr", 32'(wb.o_wbs_adr), 32'd4);
    tick();
    check_eq("rd_c2_we", 32'(wb.o_wbs_we), 32'd0);
    check_eq("rd_c2_val", 32'(data_val), 32'd0);
    tick();
    check_eq("rd_c3_flags", {28'd0, data_val, done, busy, err}, 32'hC);
    check_eq("rd_c3_data", 32'(rdata), 32'h02);
    tick();
    check_eq("rd_c4_val", {30'd0, data_val, done}, 32'd0);
    check_eq("rd_c4_hold", 32'(rdata), 32'h02);

    // Level polling: 0x02, 0x02, 0x00
    ren = 1'b1; addr = 3'd4;
    dones = 0; vals = 0; rises = 0; prev_stb = 1'b0;
    for (int c = 0; c < 40 && vals < 3; c++) begin
      tick();
      if (wb.o_wbs_stb && !prev_stb) rises++;
      prev_stb = wb.o_wbs_stb;
      if (done) dones++;
      if (data_val) begin
        vseq[vals] = rdata;
        vals++;
      end
      if (vals == 3) ren = 1'b0;
    end
    ren = 1'b0;
    check_eq("poll_vals", 32'(vals), 32'd3);
    check_eq("poll_dones", 32'(dones), 32'd3);
    check_eq("poll_stb_rises", 32'(rises), 32'd3);
    check_eq("poll_seq", {8'd0, vseq[0], vseq[1], vseq[2]}, 32'h00020200);
    tick();
    check_eq("poll_idle", {30'd0, wb.o_wbs_stb, busy}, 32'd0);
    check_eq("poll_final_data", 32'(rdata), 32'h00);

    // Priority and request during XFER
    wr_base = wr_cnt;
    dones = 0;
    wren = 1'b1; ren = 1'b1; addr = 3'd1; wdata = 8'h5A;
    tick();
    wren = 1'b0; ren = 1'b0;
    check_eq("pri_we", 32'(wb.o_wbs_we), 32'd1);
    check_eq("pri_adr_dat", {21'd0, wb.o_wbs_adr, wb.o_wbs_dat}, {21'd0, 3'd1, 8'h5A});
    wren = 1'b1; addr = 3'd6; wdata = 8'h33;
    tick();
    if (done) dones++;
    check_eq("pri_c2_hold", {21'd0, wb.o_wbs_adr, wb.o_wbs_dat}, {21'd0, 3'd1, 8'h5A});
    tick();
    wren = 1'b0;
    if (done) dones++;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (done) dones++;
    end
    check_eq("pri_dones", 32'(dones), 32'd1);
    check_eq("pri_wr_cnt", 32'(wr_cnt - wr_base), 32'd1);
    check_eq("pri_wr_ad", {21'd0, wr_adr, wr_dat}, {21'd0, 3'd1, 8'h5A});

    // Timeout with ACK_TIMEOUT=4: err at cycle 6, stb visible from cycle 1
    slv_mute = 1'b1;
    err_cyc = 0; err_n = 0; dones = 0;
    ren = 1'b1; addr = 3'd3;
    for (int c = 1; c <= 8; c++) begin
      tick();
      ren = 1'b0;
      if (err) begin
        err_n++;
        err_cyc = c;
        check_eq("to_done_with_err", 32'(done), 32'd1);
        check_eq("to_cyc_low", {30'd0, wb.o_wbs_cyc, wb.o_wbs_stb}, 32'd0);
        check_eq("to_no_val", 32'(data_val), 32'd0);
        check_eq("to_data_kept", 32'(rdata), 32'h00);
      end
      if (done) dones++;
      if (c == 5) check_eq("to_c5_stb", 32'(wb.o_wbs_stb), 32'd1);
    end
    check_eq("to_err_cycle", 32'(err_cyc), 32'd6);
    check_eq("to_err_count", 32'(err_n), 32'd1);
    check_eq("to_done_count", 32'(dones), 32'd1);

    // Reset mid-transfer, then a clean write
    wren = 1'b1; addr = 3'd7; wdata = 8'hC3;
    tick();
    wren = 1'b0;
    check_eq("rst_mid_stb", 32'(wb.o_wbs_stb), 32'd1);
    rst_n = 1'b0;
    tick();
    check_all_zero("rst_mid");
    rst_n = 1'b1;
    slv_mute = 1'b0;
    dones = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (done) dones++;
    end
    check_eq("rst_no_done", 32'(dones), 32'd0);
    wr_base = wr_cnt;
    wren = 1'b1; addr = 3'd5; wdata = 8'h3C;
    tick();
    wren = 1'b0;
    tick();
    tick();
    check_eq("post_rst_done", {30'd0, done, err}, 32'h2);
    tick();
    check_eq("post_rst_wr", {21'd0, wr_adr, wr_dat}, {21'd0, 3'd5, 8'h3C});
    check_eq("post_rst_wr_cnt", 32'(wr_cnt - wr_base), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_i2c_bus_master.md
# wb_i2c_bus_master

Single-transfer Wishbone bus master that turns one-cycle read/write requests from a local sequencer into classic Wishbone cycles on an 8-bit, 3-bit-address slave bus. Its target slave is the I2C master core's register file: prescaler, control, TX/RX and command/status registers. It sits between a polling state machine (e.g. the user-IO expander poller) and that I2C core, and reports completion, read data and bus timeouts back to the sequencer.

## Interface
- ACK_TIMEOUT, 255: cycles to wait for `i_wbs_ack` before aborting; 0 disables the timeout.
- i_clk  in  1  system clock; all logic on rising edge.
- i_reset  in  1  reset, synchronous, active-low (one clock; reset is synchronous and active-low).
- o_wbs_adr  out  3  Wishbone address.
- o_wbs_dat  out  8  Wishbone write data.
- i_wbs_dat  in  8  Wishbone read data.
- o_wbs_we  out  1  write enable.
- o_wbs_stb  out  1  strobe.
- i_wbs_ack  in  1  slave acknowledge.
- o_wbs_cyc  out  1  cycle.
- i_ren  in  1  read request; may be held high (level-tolerant).
- i_wren  in  1  write request.
- i_data  in  8  write data, sampled with the request.
- i_addr  in  3  register address, sampled with the request.
- o_data  out  8  last read data; holds until the next successful read.
- o_data_val  out  1  one-cycle pulse: o_data updated.
- o_done  out  1  one-cycle pulse: transfer finished (read, write or timeout).
- o_busy  out  1  high while a transfer is in progress.
- o_err  out  1  one-cycle pulse with o_done when the transfer timed out.

## Operation
- States: IDLE, XFER.
- IDLE: if i_wren=1, latch i_addr/i_data, set we=1, go XFER. Else if i_ren=1, latch i_addr, set we=0, go XFER. Write has priority when both are high. Requests are only sampled in IDLE; requests arriving in XFER are ignored, not queued.
- XFER: cyc=stb=1, adr/dat/we held constant.
  - On i_wbs_ack=1: drop cyc/stb/we next cycle, pulse o_done, return to IDLE.
  - If the transfer was a read, also register i_wbs_dat into o_data and pulse o_data_val.
- Timeout: a counter clears on entry to XFER and increments each XFER cycle without ack. When it reaches ACK_TIMEOUT: drop cyc/stb, pulse o_done and o_err, no o_data_val, o_data unchanged, return to IDLE.
- An ack arriving outside XFER is ignored.
- o_wbs_dat is don't-care for reads; drive the latched value.
- Reset (i_reset=0 at a clock edge): state IDLE; every output 0; timeout counter 0. A transfer in progress is abandoned without o_done.

## Timing
- Request sampled at edge 0 → cyc/stb/adr/we valid after edge 1.
- Ack sampled high at edge k → after edge k+1: cyc/stb low, o_done=1 (and o_data/o_data_val for reads). o_done is high for exactly one cycle.
- Zero-wait slave (ack in the first XFER cycle) → request to o_done = 2 cycles.
- The I2C core acks one cycle after stb, giving a 3-cycle round trip.
- Back-to-back: a request held through the o_done cycle is accepted in that cycle (state is IDLE). The next stb follows after one bus-idle cycle, so stb is never high for two consecutive transfers without a low cycle between them.
- o_busy = (state==XFER), registered.
- Timeout: with ACK_TIMEOUT=N and no ack, o_err/o_done assert N+1 cycles after stb first rises.

## Test plan
- Write: i_wren pulse, addr=3'b010, data=8'h80; slave acks 1 cycle after stb → cyc/stb/we high exactly 2 cycles with adr=2, dat=80; o_done pulse at cycle 3; o_data_val stays 0.
- Read: i_ren pulse, addr=3'b100; slave returns 8'h02 with ack → o_data=8'h02 and o_data_val=o_done=1 for one cycle; we=0 throughout.
- Level read polling: i_ren held high; slave returns 8'h02, 8'h02, 8'h00 → three distinct cycles, stb low ≥1 cycle between each, o_data_val once per cycle, final o_data=8'h00.
- Priority/busy: i_wren and i_ren high together → write cycle only. A second i_wren during XFER → ignored; exactly one o_done.
- Timeout: ACK_TIMEOUT=4, slave never acks → o_done=o_err=1 one cycle, 5 cycles after stb rise; cyc low; o_data unchanged.
- Reset mid-transfer: i_reset=0 while stb=1 → next edge all outputs 0, no o_done. After release, a new write completes normally.
